// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a registered flag file and a start/done handshake.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   start      operation request, sampled only while busy=0
//   x, y       WIDTH-bit operands, captured when start is accepted
//   operation  4-bit opcode, captured when start is accepted
//   busy       high while a MUL/DIV iteration is in progress
//   done       one-cycle pulse when out/flags have been updated
//   out        2*WIDTH-bit registered result
//   flags      {carry, zero, neg, overflow}, registered
//
// Configuration macro SEQ_ALU_DIV_EN: when defined, opcode F is an iterative restoring
// divider. When undefined there is no divider; opcode F completes in one cycle with
// out=0 and flags={0,1,0,1}.
module seq_alu #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   input  logic [3:0]           operation,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   out,
   output logic [3:0]           flags
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OpAdd = 4'h0;
   localparam logic [3:0] OpSub = 4'h1;
   localparam logic [3:0] OpAdc = 4'h2;
   localparam logic [3:0] OpSbb = 4'h3;
   localparam logic [3:0] OpAnd = 4'h4;
   localparam logic [3:0] OpOr  = 4'h5;
   localparam logic [3:0] OpXor = 4'h6;
   localparam logic [3:0] OpNot = 4'h7;
   localparam logic [3:0] OpShl = 4'h8;
   localparam logic [3:0] OpShr = 4'h9;
   localparam logic [3:0] OpSar = 4'hA;
   localparam logic [3:0] OpInc = 4'hB;
   localparam logic [3:0] OpDec = 4'hC;
   localparam logic [3:0] OpCmp = 4'hD;
   localparam logic [3:0] OpMul = 4'hE;
   localparam logic [3:0] OpDiv = 4'hF;

   typedef enum logic [1:0] {StIdle, StIter, StDone} state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   out_q, out_d;
   logic [3:0]           flags_q, flags_d;
   // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient/dividend}
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   // MUL: multiplicand; DIV: divisor
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [CW-1:0]        cnt_q, cnt_d;
`ifdef SEQ_ALU_DIV_EN
   logic                 is_div_q, is_div_d;
`endif

   // Single-cycle datapath
   logic [WIDTH-1:0]     sc_b;
   logic                 sc_cin;
   logic [WIDTH:0]       add_w, sub_w;
   logic                 add_v, sub_v;
   logic [WIDTH-1:0]     sc_res;
   logic                 sc_c, sc_v;

   always_comb begin
      sc_b   = y;
      sc_cin = 1'b0;
      if (operation == OpInc || operation == OpDec) begin
         sc_b = {{(WIDTH-1){1'b0}}, 1'b1};
      end
      if (operation == OpAdc || operation == OpSbb) begin
         sc_cin = flags_q[3];
      end
   end

   assign add_w = {1'b0, x} + {1'b0, sc_b} + {{WIDTH{1'b0}}, sc_cin};
   // Bit WIDTH of the difference is the borrow: set when x < sc_b + sc_cin.
   assign sub_w = {1'b0, x} - {1'b0, sc_b} - {{WIDTH{1'b0}}, sc_cin};
   assign add_v = (x[WIDTH-1] == sc_b[WIDTH-1]) && (add_w[WIDTH-1] != x[WIDTH-1]);
   assign sub_v = (x[WIDTH-1] != sc_b[WIDTH-1]) && (sub_w[WIDTH-1] != x[WIDTH-1]);

   always_comb begin
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      case (operation)
         OpAdd, OpAdc, OpInc: begin
            sc_res = add_w[WIDTH-1:0];
            sc_c   = add_w[WIDTH];
            sc_v   = add_v;
         end
         OpSub, OpSbb, OpDec, OpCmp: begin
            sc_res = sub_w[WIDTH-1:0];
            sc_c   = sub_w[WIDTH];
            sc_v   = sub_v;
         end
         OpAnd: sc_res = x & y;
         OpOr:  sc_res = x | y;
         OpXor: sc_res = x ^ y;
         OpNot: sc_res = ~x;
         OpShl: begin
            sc_res = {x[WIDTH-2:0], 1'b0};
            sc_c   = x[WIDTH-1];
         end
         OpShr: begin
            sc_res = {1'b0, x[WIDTH-1:1]};
            sc_c   = x[0];
         end
         OpSar: begin
            sc_res = {x[WIDTH-1], x[WIDTH-1:1]};
            sc_c   = x[0];
         end
         default: ;
      endcase
   end

   // Iterative step: shift-add multiply, optionally restoring divide
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [2*WIDTH-1:0]   step;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH:0]       rem_sh, rem_diff;
   logic [2*WIDTH-1:0]   div_next;

   assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign rem_diff = rem_sh - {1'b0, opnd_q};
   // Remainder stays below the divisor, so the restored value fits in WIDTH bits.
   assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   assign step     = is_div_q ? div_next : mul_next;
`else
   assign step     = mul_next;
`endif

   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      flags_d  = flags_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
`ifdef SEQ_ALU_DIV_EN
      is_div_d = is_div_q;
`endif
      case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (start) begin
               if (operation == OpMul) begin
                  state_d  = StIter;
                  opnd_d   = x;
                  acc_d    = {{WIDTH{1'b0}}, y};
                  cnt_d    = '0;
`ifdef SEQ_ALU_DIV_EN
                  is_div_d = 1'b0;
`endif
               end else if (operation == OpDiv) begin
`ifdef SEQ_ALU_DIV_EN
                  if (y == '0) begin
                     // Quotient of all ones is never zero, so zero stays clear.
                     state_d = StDone;
                     out_d   = {x, {WIDTH{1'b1}}};
                     flags_d = {1'b0, 1'b0, x[WIDTH-1], 1'b1};
                  end else begin
                     state_d  = StIter;
                     opnd_d   = y;
                     acc_d    = {{WIDTH{1'b0}}, x};
                     cnt_d    = '0;
                     is_div_d = 1'b1;
                  end
`else
                  state_d = StDone;
                  out_d   = '0;
                  flags_d = 4'b0101;
`endif
               end else begin
                  state_d = StDone;
                  if (operation != OpCmp) begin
                     out_d = {{WIDTH{1'b0}}, sc_res};
                  end
                  flags_d = {sc_c, (sc_res == '0), sc_res[WIDTH-1], sc_v};
               end
            end
         end
         StIter: begin
            acc_d = step;
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = StDone;
               out_d   = step;
`ifdef SEQ_ALU_DIV_EN
               flags_d = {(!is_div_q && (step[2*WIDTH-1:WIDTH] != '0)), (step == '0),
                          step[2*WIDTH-1], 1'b0};
`else
               flags_d = {(step[2*WIDTH-1:WIDTH] != '0), (step == '0), step[2*WIDTH-1], 1'b0};
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         out_q    <= '0;
         flags_q  <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
`ifdef SEQ_ALU_DIV_EN
         is_div_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         flags_q  <= flags_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
`ifdef SEQ_ALU_DIV_EN
         is_div_q <= is_div_d;
`endif
      end
   end

   assign busy  = (state_q == StIter);
   assign done  = (state_q == StDone);
   assign out   = out_q;
   assign flags = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (WIDTH=8). Stimulus pushes the expected
// result, flags and completion cycle; a monitor on the falling edge pops and compares
// whenever done is seen, and also tracks busy against the bench's expected busy.
module tb_seq_alu;

   localparam logic [3:0] OpAdd = 4'h0;
   localparam logic [3:0] OpSub = 4'h1;
   localparam logic [3:0] OpAdc = 4'h2;
   localparam logic [3:0] OpSbb = 4'h3;
   localparam logic [3:0] OpAnd = 4'h4;
   localparam logic [3:0] OpOr  = 4'h5;
   localparam logic [3:0] OpXor = 4'h6;
   localparam logic [3:0] OpNot = 4'h7;
   localparam logic [3:0] OpShl = 4'h8;
   localparam logic [3:0] OpShr = 4'h9;
   localparam logic [3:0] OpSar = 4'hA;
   localparam logic [3:0] OpInc = 4'hB;
   localparam logic [3:0] OpDec = 4'hC;
   localparam logic [3:0] OpCmp = 4'hD;
   localparam logic [3:0] OpMul = 4'hE;
   localparam logic [3:0] OpDiv = 4'hF;

   logic        clock;
   logic        reset;
   logic        start;
   logic [7:0]  x;
   logic [7:0]  y;
   logic [3:0]  operation;
   logic        busy;
   logic        done;
   logic [15:0] out;
   logic [3:0]  flags;

   seq_alu #(.WIDTH(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .x         (x),
      .y         (y),
      .operation (operation),
      .busy      (busy),
      .done      (done),
      .out       (out),
      .flags     (flags)
   );

   typedef struct {
      logic [15:0] o;
      logic [3:0]  f;
      int          due;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic exp_busy = 1'b0;
   logic chk_rst = 1'b0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clock) begin
      if (cyc > 0) check("busy", {31'b0, busy}, {31'b0, exp_busy});
      if (chk_rst) begin
         check("reset out", {16'b0, out}, 32'h0);
         check("reset flags", {28'b0, flags}, 32'h0);
         check("reset done", {31'b0, done}, 32'h0);
      end
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious done", {31'b0, done}, 32'h0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, " out"}, {16'b0, out}, {16'b0, e.o});
            check({e.name, " flags"}, {28'b0, flags}, {28'b0, e.f});
            check({e.name, " done cycle"}, cyc, e.due);
         end
      end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
         exp_t e;
         e = sb_q.pop_front();
         check({e.name, " timeout"}, cyc, e.due);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drives one request and records its expected completion; returns one cycle later.
   task automatic issue(input string nm, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] eo, input logic [3:0] ef,
                        input int lat);
      exp_t e;
      start = 1'b1;
      operation = op;
      x = a;
      y = b;
      e.o = eo;
      e.f = ef;
      e.due = cyc + lat;
      e.name = nm;
      sb_q.push_back(e);
      tick();
   endtask

   task automatic single(input string nm, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] eo, input logic [3:0] ef);
      issue(nm, op, a, b, eo, ef, 1);
      start = 1'b0;
      tick();
   endtask

   // MUL/DIV with busy tracking; poke pulses a stray start mid-iteration.
   task automatic iter_op(input string nm, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] eo, input logic [3:0] ef,
                          input bit poke);
      issue(nm, op, a, b, eo, ef, 9);
      exp_busy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (poke && i == 3) begin
            start = 1'b1;
            operation = OpAdd;
            x = 8'h01;
            y = 8'h01;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      exp_busy = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      x = '0;
      y = '0;
      operation = '0;
      repeat (3) tick();
      reset = 1'b0;
      chk_rst = 1'b1;
      repeat (2) tick();
      chk_rst = 1'b0;

      // flags are {C, Z, N, V}
      single("add ff+01", OpAdd, 8'hFF, 8'h01, 16'h0000, 4'b1100);
      single("adc 00+00+c", OpAdc, 8'h00, 8'h00, 16'h0001, 4'b0000);
      single("sub 80-01", OpSub, 8'h80, 8'h01, 16'h007F, 4'b0001);
      single("cmp 05,05", OpCmp, 8'h05, 8'h05, 16'h007F, 4'b0100);

      iter_op("mul ff*ff", OpMul, 8'hFF, 8'hFF, 16'hFE01, 4'b1010, 1'b1);

`ifdef SEQ_ALU_DIV_EN
      iter_op("div 200/7", OpDiv, 8'd200, 8'd7, 16'h041C, 4'b0000, 1'b0);
      single("div 2a/0", OpDiv, 8'h2A, 8'h00, 16'h2AFF, 4'b0001);
`else
      single("div 200/7 off", OpDiv, 8'd200, 8'd7, 16'h0000, 4'b0101);
      single("div 2a/0 off", OpDiv, 8'h2A, 8'h00, 16'h0000, 4'b0101);
`endif

      // Back-to-back: each start is held through the previous done cycle.
      issue("shl 81", OpShl, 8'h81, 8'h00, 16'h0002, 4'b1000, 1);
      issue("sar 80", OpSar, 8'h80, 8'h00, 16'h00C0, 4'b0010, 1);
      issue("inc ff", OpInc, 8'hFF, 8'h00, 16'h0000, 4'b1100, 1);
      start = 1'b0;
      tick();

      single("sbb 05-02-c", OpSbb, 8'h05, 8'h02, 16'h0002, 4'b0000);
      single("and f0,3c", OpAnd, 8'hF0, 8'h3C, 16'h0030, 4'b0000);
      single("xor ff,ff", OpXor, 8'hFF, 8'hFF, 16'h0000, 4'b0100);
      single("not 0f", OpNot, 8'h0F, 8'h00, 16'h00F0, 4'b0010);
      single("or 00,00", OpOr, 8'h00, 8'h00, 16'h0000, 4'b0100);
      single("shr 01", OpShr, 8'h01, 8'h00, 16'h0000, 4'b1100);
      single("dec 80", OpDec, 8'h80, 8'h00, 16'h007F, 4'b0001);

      // Reset during MUL: no expectation pushed, so any done is spurious.
      start = 1'b1;
      operation = OpMul;
      x = 8'h03;
      y = 8'h04;
      tick();
      start = 1'b0;
      exp_busy = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_busy = 1'b0;
      chk_rst = 1'b1;
      tick();
      chk_rst = 1'b0;
      repeat (12) tick();

      iter_op("mul 0f*11", OpMul, 8'h0F, 8'h11, 16'h00FF, 4'b0000, 1'b0);

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
